// File: rtl/mc_main_control_pkg.sv
// Shared encodings for the multicycle main control FSM: RV32I opcodes,
// ALUOp codes, datapath mux selects, trap causes and the FSM state type.
// Ports: none (package).
package mc_main_control_pkg;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALUOp into the ALU control decoder
  localparam logic [2:0] ALUOP_IL    = 3'b000;  // add (loads, stores, PC+4, targets)
  localparam logic [2:0] ALUOP_B     = 3'b001;  // subtract for branch compare
  localparam logic [2:0] ALUOP_R     = 3'b010;
  localparam logic [2:0] ALUOP_I     = 3'b011;
  localparam logic [2:0] ALUOP_LUI   = 3'b100;
  localparam logic [2:0] ALUOP_AUIPC = 3'b101;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_RS1    = 2'b01;
  localparam logic [1:0] SRCA_OLDPC  = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;
  localparam logic [1:0] M2R_ALUOUT  = 2'b00;
  localparam logic [1:0] M2R_MDR     = 2'b01;
  localparam logic [1:0] M2R_PC      = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // Encoding 4'hF is deliberately unused; the FSM sends it to TRAP.
  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EX_ADDR = 4'd3,
    ST_MEM_RD  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_WB_MEM  = 4'd6,
    ST_EX_R    = 4'd7,
    ST_EX_I    = 4'd8,
    ST_EX_U    = 4'd9,
    ST_WB_ALU  = 4'd10,
    ST_EX_BR   = 4'd11,
    ST_EX_JAL  = 4'd12,
    ST_EX_JALR = 4'd13,
    ST_TRAP    = 4'd14
  } state_e;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-cycle counter with timeout compare.
// Latency: o_Expired is combinational from the registered count.
// Ports: i_Clk, i_Rst_n (async low), i_Clear (wins), i_Enable (count up), o_Expired.
module mc_wait_timer
  import mc_main_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expired
);

  // Count never exceeds MEM_TIMEOUT-1: the FSM leaves the wait state there.
  localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [W-1:0] r_count;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_count <= '0;
    end else if (i_Clear) begin
      r_count <= '0;
    end else if (i_Enable) begin
      r_count <= r_count + W'(1);
    end
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout_on
      assign o_Expired = (r_count == W'(MEM_TIMEOUT - 1));
    end else begin : g_timeout_off
      assign o_Expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mc_main_control.sv
// Multicycle RV32I main control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing.
// Latency: 3 (BR/JAL/JALR), 4 (R/I/U/STORE), 5 (LOAD) cycles with zero-wait memory.
// Backpressure: stalls in FETCH/MEM states until i_MemReady; traps after MEM_TIMEOUT waits.
// Ports: i_Clk, i_Rst_n, i_Opcode, i_MemReady in; ALUOp, mux selects, write enables,
//        o_Retire pulse, o_RetireCount, o_TrapCause out.
module mc_main_control
  import mc_main_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic [6:0]       i_Opcode,
  input  logic             i_MemReady,
  output logic [2:0]       o_ALUOp,
  output logic [1:0]       o_ALUSrcA,
  output logic [1:0]       o_ALUSrcB,
  output logic [1:0]       o_PCSource,
  output logic [1:0]       o_MemtoReg,
  output logic             o_IorD,
  output logic             o_MemRead,
  output logic             o_MemWrite,
  output logic             o_IRWrite,
  output logic             o_PCWrite,
  output logic             o_PCWriteCond,
  output logic             o_RegWrite,
  output logic             o_Retire,
  output logic [CNT_W-1:0] o_RetireCount,
  output logic [1:0]       o_TrapCause
);

  state_e           r_state;
  logic [1:0]       r_trap_cause;
  logic [CNT_W-1:0] r_retire_cnt;

  logic w_mem_state;
  logic w_wait;
  logic w_expired;
  logic w_timeout;

  assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
  assign w_wait      = w_mem_state && !i_MemReady;
  assign w_timeout   = w_wait && w_expired;

  // Every non-waiting cycle either changes state or sits in TRAP, so clearing
  // whenever we are not stalled (or are about to trap) clears on each state change.
  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_Clear  (!w_wait || w_expired),
    .i_Enable (w_wait),
    .o_Expired(w_expired)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state      <= ST_RESET;
      r_trap_cause <= TRAP_NONE;
      r_retire_cnt <= '0;
    end else begin
      if (o_Retire) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_state      <= ST_TRAP;
        r_trap_cause <= TRAP_TIMEOUT;
      end else begin
        case (r_state)
          ST_RESET:  r_state <= ST_FETCH;
          ST_FETCH:  if (i_MemReady) r_state <= ST_DECODE;
          ST_DECODE: begin
            case (i_Opcode)
              OPC_LOAD, OPC_STORE: r_state <= ST_EX_ADDR;
              OPC_OP:              r_state <= ST_EX_R;
              OPC_OP_IMM:          r_state <= ST_EX_I;
              OPC_LUI, OPC_AUIPC:  r_state <= ST_EX_U;
              OPC_BRANCH:          r_state <= ST_EX_BR;
              OPC_JAL:             r_state <= ST_EX_JAL;
              OPC_JALR:            r_state <= ST_EX_JALR;
              default: begin
                r_state      <= ST_TRAP;
                r_trap_cause <= TRAP_ILLEGAL;
              end
            endcase
          end
          // Opcode is re-read from IR here rather than carried from DECODE.
          ST_EX_ADDR: r_state <= (i_Opcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
          ST_MEM_RD:  if (i_MemReady) r_state <= ST_WB_MEM;
          ST_MEM_WR:  if (i_MemReady) r_state <= ST_FETCH;
          ST_EX_R, ST_EX_I, ST_EX_U:  r_state <= ST_WB_ALU;
          ST_WB_MEM, ST_WB_ALU, ST_EX_BR, ST_EX_JAL, ST_EX_JALR: r_state <= ST_FETCH;
          ST_TRAP:    r_state <= ST_TRAP;
          default: begin
            r_state      <= ST_TRAP;
            r_trap_cause <= TRAP_ILLEGAL;
          end
        endcase
      end
    end
  end

  // Outputs decode straight from the state so an async reset drops every
  // enable immediately; ready-qualified enables follow i_MemReady in-cycle.
  always_comb begin
    o_ALUOp       = ALUOP_IL;
    o_ALUSrcA     = SRCA_PC;
    o_ALUSrcB     = SRCB_RS2;
    o_PCSource    = PCSRC_ALU;
    o_MemtoReg    = M2R_ALUOUT;
    o_IorD        = 1'b0;
    o_MemRead     = 1'b0;
    o_MemWrite    = 1'b0;
    o_IRWrite     = 1'b0;
    o_PCWrite     = 1'b0;
    o_PCWriteCond = 1'b0;
    o_RegWrite    = 1'b0;
    o_Retire      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        o_MemRead = 1'b1;
        o_ALUSrcB = SRCB_FOUR;
        o_IRWrite = i_MemReady;
        o_PCWrite = i_MemReady;
      end
      ST_DECODE: begin
        o_ALUSrcA = SRCA_OLDPC;
        o_ALUSrcB = SRCB_IMM;
      end
      ST_EX_ADDR, ST_EX_I: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUSrcB = SRCB_IMM;
        o_ALUOp   = (r_state == ST_EX_I) ? ALUOP_I : ALUOP_IL;
      end
      ST_MEM_RD: begin
        o_MemRead = 1'b1;
        o_IorD    = 1'b1;
      end
      ST_MEM_WR: begin
        o_MemWrite = 1'b1;
        o_IorD     = 1'b1;
        o_Retire   = i_MemReady;
      end
      ST_WB_MEM: begin
        o_RegWrite = 1'b1;
        o_MemtoReg = M2R_MDR;
        o_Retire   = 1'b1;
      end
      ST_EX_R: begin
        o_ALUSrcA = SRCA_RS1;
        o_ALUOp   = ALUOP_R;
      end
      ST_EX_U: begin
        o_ALUSrcA = SRCA_OLDPC;
        o_ALUSrcB = SRCB_IMM;
        o_ALUOp   = (i_Opcode == OPC_LUI) ? ALUOP_LUI : ALUOP_AUIPC;
      end
      ST_WB_ALU: begin
        o_RegWrite = 1'b1;
        o_Retire   = 1'b1;
      end
      ST_EX_BR: begin
        o_ALUSrcA     = SRCA_RS1;
        o_ALUOp       = ALUOP_B;
        o_PCWriteCond = 1'b1;
        o_PCSource    = PCSRC_ALUOUT;
        o_Retire      = 1'b1;
      end
      ST_EX_JAL: begin
        o_RegWrite = 1'b1;
        o_MemtoReg = M2R_PC;
        o_PCWrite  = 1'b1;
        o_PCSource = PCSRC_ALUOUT;
        o_Retire   = 1'b1;
      end
      ST_EX_JALR: begin
        o_ALUSrcA  = SRCA_RS1;
        o_ALUSrcB  = SRCB_IMM;
        o_RegWrite = 1'b1;
        o_MemtoReg = M2R_PC;
        o_PCWrite  = 1'b1;
        o_PCSource = PCSRC_JALR;
        o_Retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_RetireCount = r_retire_cnt;
  assign o_TrapCause   = r_trap_cause;

endmodule

// File: tb/tb_mc_main_control.sv
module tb_mc_main_control;

  localparam int T  = 8;
  localparam int CW = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_U = 4;
  localparam int K_BR = 5, K_JAL = 6, K_JALR = 7, K_ILL = 8;
  localparam int P_RST = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_TRAP = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [6:0]    opc;
  logic          rdy;
  logic [2:0]    alu_op;
  logic [1:0]    src_a, src_b, pc_src, mem_to_reg, trap_cause;
  logic          iord, mem_rd, mem_wr, ir_wr, pc_wr, pc_wr_cond, reg_wr, retire;
  logic [CW-1:0] cnt;

  mc_main_control #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Opcode(opc), .i_MemReady(rdy),
    .o_ALUOp(alu_op), .o_ALUSrcA(src_a), .o_ALUSrcB(src_b), .o_PCSource(pc_src),
    .o_MemtoReg(mem_to_reg), .o_IorD(iord), .o_MemRead(mem_rd), .o_MemWrite(mem_wr),
    .o_IRWrite(ir_wr), .o_PCWrite(pc_wr), .o_PCWriteCond(pc_wr_cond), .o_RegWrite(reg_wr),
    .o_Retire(retire), .o_RetireCount(cnt), .o_TrapCause(trap_cause)
  );

  logic [20:0] dut_v;
  assign dut_v = {alu_op, src_a, src_b, pc_src, mem_to_reg, iord, mem_rd, mem_wr,
                  ir_wr, pc_wr, pc_wr_cond, reg_wr, retire, trap_cause};

  int checks = 0;
  int failures = 0;

  // Reference model: instruction phase, wait count, trap cause, retired count.
  int         m_phase;
  int         m_wait;
  int         m_cnt;
  logic [1:0] m_cause;

  logic [6:0] legal [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      OP_LOAD:          return K_LOAD;
      OP_STORE:         return K_STORE;
      OP_R:             return K_R;
      OP_I:             return K_I;
      OP_LUI, OP_AUIPC: return K_U;
      OP_BR:            return K_BR;
      OP_JAL:           return K_JAL;
      OP_JALR:          return K_JALR;
      default:          return K_ILL;
    endcase
  endfunction

  function automatic logic [20:0] exp_vec(input int ph, input logic [6:0] op, input logic r,
                                          input logic [1:0] cause);
    logic [2:0] alu;
    logic [1:0] sa, sb, pcs, m2r;
    logic io, mr, mw, irw, pcw, pcwc, rw, ret;
    int k;
    k = kind_of(op);
    alu = 3'd0; sa = 2'd0; sb = 2'd0; pcs = 2'd0; m2r = 2'd0;
    io = 0; mr = 0; mw = 0; irw = 0; pcw = 0; pcwc = 0; rw = 0; ret = 0;
    case (ph)
      P_FETCH: begin mr = 1; sb = 2'd1; irw = r; pcw = r; end
      P_DEC:   begin sa = 2'd2; sb = 2'd2; end
      P_EXEC: begin
        if (k == K_LOAD || k == K_STORE) begin sa = 2'd1; sb = 2'd2; end
        else if (k == K_R)   begin sa = 2'd1; alu = 3'd2; end
        else if (k == K_I)   begin sa = 2'd1; sb = 2'd2; alu = 3'd3; end
        else if (k == K_U)   begin sa = 2'd2; sb = 2'd2; alu = (op == OP_LUI) ? 3'd4 : 3'd5; end
        else if (k == K_BR)  begin sa = 2'd1; alu = 3'd1; pcwc = 1; pcs = 2'd1; ret = 1; end
        else if (k == K_JAL) begin rw = 1; m2r = 2'd2; pcw = 1; pcs = 2'd1; ret = 1; end
        else if (k == K_JALR) begin
          sa = 2'd1; sb = 2'd2; rw = 1; m2r = 2'd2; pcw = 1; pcs = 2'd2; ret = 1;
        end
      end
      P_MEM: begin
        io = 1;
        if (k == K_LOAD) mr = 1;
        else begin mw = 1; ret = r; end
      end
      P_WB: begin rw = 1; ret = 1; m2r = (k == K_LOAD) ? 2'd1 : 2'd0; end
      default: ;
    endcase
    return {alu, sa, sb, pcs, m2r, io, mr, mw, irw, pcw, pcwc, rw, ret, cause};
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    logic [20:0] v;
    int k;
    v = exp_vec(m_phase, opc, rdy, m_cause);
    k = kind_of(opc);
    case (m_phase)
      P_RST: m_phase = P_FETCH;
      P_FETCH, P_MEM: begin
        if (rdy) begin
          m_wait = 0;
          if (m_phase == P_FETCH) m_phase = P_DEC;
          else m_phase = (k == K_LOAD) ? P_WB : P_FETCH;
        end else if (m_wait == T - 1) begin
          m_wait = 0; m_phase = P_TRAP; m_cause = 2'b10;
        end else begin
          m_wait++;
        end
      end
      P_DEC: begin
        if (k == K_ILL) begin m_phase = P_TRAP; m_cause = 2'b01; end
        else m_phase = P_EXEC;
      end
      P_EXEC: begin
        if (k == K_LOAD || k == K_STORE) m_phase = P_MEM;
        else if (k == K_R || k == K_I || k == K_U) m_phase = P_WB;
        else m_phase = P_FETCH;
      end
      P_WB: m_phase = P_FETCH;
      default: ;
    endcase
    if (v[2]) m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  // Called just after a rising edge: apply inputs, then compare at the falling edge.
  task automatic drive(input logic [6:0] op, input logic r);
    logic [20:0] e;
    opc = op;
    rdy = r;
    @(negedge clk);
    #1;
    e = exp_vec(m_phase, opc, rdy, m_cause);
    check("model_outputs", 32'(dut_v), 32'(e));
    check("model_retire_count", 32'(cnt), 32'(m_cnt));
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, then passes the RESET cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs_zero", 32'(dut_v), 32'd0);
    check("reset_count_zero", 32'(cnt), 32'd0);
    m_phase = P_RST; m_wait = 0; m_cnt = 0; m_cause = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(OP_R, 1'b1);
    check("reset_state_memread", 32'(mem_rd), 32'd0);
    advance();
  endtask

  // Runs one instruction from FETCH until its retire cycle, stalling the MEM phase.
  task automatic run_instr(input logic [6:0] op, input int stall, output int cyc, output int memc,
                           output logic [2:0] ex_alu, output logic [1:0] ex_sa,
                           output logic [1:0] ex_pcs, output logic ex_pcwc,
                           output logic [1:0] ret_m2r);
    int st;
    logic r;
    st = stall; cyc = 0; memc = 0;
    ex_alu = 3'd7; ex_sa = 2'd3; ex_pcs = 2'd3; ex_pcwc = 1'b0; ret_m2r = 2'd3;
    for (int i = 0; i < 40; i++) begin
      r = 1'b1;
      if (m_phase == P_MEM && st > 0) begin r = 1'b0; st--; end
      drive(op, r);
      cyc++;
      if (mem_rd && iord) memc++;
      if (m_phase == P_EXEC) begin
        ex_alu = alu_op; ex_sa = src_a; ex_pcs = pc_src; ex_pcwc = pc_wr_cond;
      end
      if (retire) begin
        ret_m2r = mem_to_reg;
        advance();
        return;
      end
      advance();
    end
    check("run_instr_retire_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, memc, trap_cycles;
    logic [2:0] ea;
    logic [1:0] esa, epcs, m2r;
    logic epcwc, bad;

    legal = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_AUIPC, OP_BR, OP_JAL, OP_JALR};
    rst_n = 1'b0; opc = 7'd0; rdy = 1'b0;
    m_phase = P_RST; m_wait = 0; m_cnt = 0; m_cause = 2'b00;
    @(posedge clk);
    #1;
    do_reset();

    // ADD with zero-wait memory
    check("add_count_before", 32'(cnt), 32'd0);
    run_instr(OP_R, 0, cyc, memc, ea, esa, epcs, epcwc, m2r);
    check("add_cycles", 32'(cyc), 32'd4);
    check("add_aluop", 32'(ea), 32'b010);
    check("add_memtoreg", 32'(m2r), 32'b00);
    check("add_count_after", 32'(cnt), 32'd1);

    // LOAD with 3 stall cycles in MEM_RD
    run_instr(OP_LOAD, 3, cyc, memc, ea, esa, epcs, epcwc, m2r);
    check("load_cycles", 32'(cyc), 32'd8);
    check("load_memread_iord_cycles", 32'(memc), 32'd4);
    check("load_memtoreg", 32'(m2r), 32'b01);

    run_instr(OP_STORE, 0, cyc, memc, ea, esa, epcs, epcwc, m2r);
    check("store_cycles", 32'(cyc), 32'd4);

    run_instr(OP_BR, 0, cyc, memc, ea, esa, epcs, epcwc, m2r);
    check("beq_cycles", 32'(cyc), 32'd3);
    check("beq_aluop", 32'(ea), 32'b001);
    check("beq_pcwritecond", 32'(epcwc), 32'd1);

    run_instr(OP_LUI, 0, cyc, memc, ea, esa, epcs, epcwc, m2r);
    check("lui_aluop", 32'(ea), 32'b100);

    run_instr(OP_AUIPC, 0, cyc, memc, ea, esa, epcs, epcwc, m2r);
    check("auipc_aluop", 32'(ea), 32'b101);
    check("auipc_srca", 32'(esa), 32'b10);

    run_instr(OP_JAL, 0, cyc, memc, ea, esa, epcs, epcwc, m2r);
    check("jal_cycles", 32'(cyc), 32'd3);
    check("jal_memtoreg", 32'(m2r), 32'b10);

    run_instr(OP_JALR, 0, cyc, memc, ea, esa, epcs, epcwc, m2r);
    check("jalr_pcsource", 32'(epcs), 32'b10);
    check("count_after_directed", 32'(cnt), 32'd8);

    // Illegal opcode traps and stays quiet
    drive(7'b0000000, 1'b1); advance();
    drive(7'b0000000, 1'b1); advance();
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(7'b0000000, 1'($urandom_range(0, 1)));
      bad = bad | reg_wr | pc_wr | mem_wr;
      advance();
    end
    check("illegal_trap_cause", 32'(trap_cause), 32'b01);
    check("illegal_no_enables", 32'(bad), 32'd0);

    // Fetch timeout: 8 unanswered fetch cycles
    do_reset();
    for (int i = 0; i < 7; i++) begin drive(OP_R, 1'b0); advance(); end
    drive(OP_R, 1'b0);
    check("timeout_8th_fetch", 32'({mem_rd, trap_cause}), 32'b100);
    advance();
    drive(OP_R, 1'b0);
    check("timeout_trap_cause", 32'(trap_cause), 32'b10);
    advance();

    // Ready on the 8th cycle wins over the timeout
    do_reset();
    for (int i = 0; i < 7; i++) begin drive(OP_R, 1'b0); advance(); end
    drive(OP_R, 1'b1);
    check("late_ready_irwrite", 32'(ir_wr), 32'd1);
    advance();
    drive(OP_R, 1'b1);
    check("late_ready_decode", 32'({src_a, trap_cause}), 32'b1000);
    advance();
    drive(OP_R, 1'b1); advance();
    drive(OP_R, 1'b1); advance();

    // Reset while stalled in MEM_RD
    drive(OP_LOAD, 1'b1); advance();
    drive(OP_LOAD, 1'b1); advance();
    drive(OP_LOAD, 1'b1); advance();
    drive(OP_LOAD, 1'b0);
    check("mem_rd_before_reset", 32'({mem_rd, iord}), 32'b11);
    do_reset();
    drive(OP_R, 1'b1);
    check("after_reset_fetch_memread", 32'(mem_rd), 32'd1);
    advance();
    drive(OP_R, 1'b1); advance();
    drive(OP_R, 1'b1); advance();
    drive(OP_R, 1'b1); advance();

    // Retire counter wrap at 2^CW
    for (int i = 0; i < 14; i++) run_instr(OP_R, 0, cyc, memc, ea, esa, epcs, epcwc, m2r);
    check("count_15", 32'(cnt), 32'd15);
    run_instr(OP_I, 0, cyc, memc, ea, esa, epcs, epcwc, m2r);
    check("count_wrap", 32'(cnt), 32'd0);

    // Randomized run against the model
    trap_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_phase == P_TRAP) begin
        trap_cycles++;
        if (trap_cycles > 3) begin
          trap_cycles = 0;
          do_reset();
        end
      end
      if (m_phase == P_FETCH) begin
        if ($urandom_range(0, 15) == 0) opc = 7'($urandom);
        else opc = legal[$urandom_range(0, 8)];
      end
      drive(opc, 1'($urandom_range(0, 9) < 7));
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
